radix_down_converter: RTL and testbench



---
 rtl/radix_down_converter.sv | 209 ++++++++++++++++++++
 tb/tb_radix_down_converter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_down_converter.sv
// Narrows a stream of binary64 values to binary16 or binary32 (RNE), or passes them through.
// Ports: clk/rstn (sync, active-low); Ctrl_sig selects the target per beat; input_* and output_* form
// valid/ready streams, output_data is zero-extended (half [15:0], single [31:0], passthrough [63:0]).
module radix_down_converter #(
    parameter bit PIPE_OUT_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  Ctrl_sig,
    input  logic        input_valid,
    output logic        input_ready,
    input  logic [63:0] input_data,
    output logic        output_valid,
    input  logic        output_ready,
    output logic [63:0] output_data
);

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    // ---------------------------------------------------------------
    // Stage 1 decode: classify and align the significand to the target
    // ---------------------------------------------------------------
    logic        in_sign;
    logic [10:0] in_exp;
    logic [51:0] in_frac;

    assign in_sign = input_data[63];
    assign in_exp  = input_data[62:52];
    assign in_frac = input_data[51:0];

    // Target limits are kept as biased binary64 exponents so no signed math is needed.
    logic [10:0] emin_b;
    logic [10:0] emax_b;
    logic [10:0] bias_adj;
    logic [4:0]  shift_cap;
    logic [10:0] shift_raw;
    logic [4:0]  shift;
    logic [78:0] aligned;
    cls_t        d_cls;
    logic [7:0]  d_exp;
    logic [22:0] d_mant;
    logic        d_guard;
    logic        d_sticky;

    always_comb begin
        if (Ctrl_sig[0]) begin
            emin_b    = 11'd897;   // 1023 - 126
            emax_b    = 11'd1150;  // 1023 + 127
            bias_adj  = 11'd896;   // 1023 - 127
            shift_cap = 5'd26;     // p + 2
        end else begin
            emin_b    = 11'd1009;  // 1023 - 14
            emax_b    = 11'd1038;  // 1023 + 15
            bias_adj  = 11'd1008;  // 1023 - 15
            shift_cap = 5'd13;
        end

        // Below the target's normal range the value becomes subnormal: shift 1.f right.
        shift_raw = (in_exp < emin_b) ? (emin_b - in_exp) : 11'd0;
        shift     = (shift_raw > {6'd0, shift_cap}) ? shift_cap : shift_raw[4:0];

        // The 27 padding zeros absorb every shift up to the cap, so nothing is lost
        // before sticky is formed. Bit 78 is the first bit below the binary point.
        aligned = 79'({1'b1, in_frac, 27'd0} >> shift);

        if (Ctrl_sig[0]) begin
            d_mant   = aligned[78:56];
            d_guard  = aligned[55];
            d_sticky = |aligned[54:0];
        end else begin
            d_mant   = {13'd0, aligned[78:69]};
            d_guard  = aligned[68];
            d_sticky = |aligned[67:0];
        end

        d_exp = (in_exp < emin_b) ? 8'd0 : 8'(in_exp - bias_adj);

        if (in_exp == 11'd0) begin
            d_cls = CLS_ZERO;                          // zero and binary64 subnormals
        end else if (in_exp == 11'h7FF) begin
            d_cls = (in_frac != 52'd0) ? CLS_NAN : CLS_INF;
        end else if (in_exp > emax_b) begin
            d_cls = CLS_INF;
        end else begin
            d_cls = CLS_NUM;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1 register
    // ---------------------------------------------------------------
    logic        s1_valid;
    logic [1:0]  s1_mode;
    logic        s1_sign;
    cls_t        s1_cls;
    logic [7:0]  s1_exp;
    logic [22:0] s1_mant;
    logic        s1_guard;
    logic        s1_sticky;
    logic [63:0] s1_raw;
    logic        s2_ready;

    assign input_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 2'd0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_NUM;
            s1_exp    <= 8'd0;
            s1_mant   <= 23'd0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_raw    <= 64'd0;
        end else if (input_ready) begin
            s1_valid <= input_valid;
            if (input_valid) begin
                s1_mode   <= Ctrl_sig;
                s1_sign   <= in_sign;
                s1_cls    <= d_cls;
                s1_exp    <= d_exp;
                s1_mant   <= d_mant;
                s1_guard  <= d_guard;
                s1_sticky <= d_sticky;
                s1_raw    <= input_data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: round to nearest even and pack
    // ---------------------------------------------------------------
    logic        round_up;
    logic [30:0] sgl_mag;
    logic [14:0] hlf_mag;
    logic [31:0] sgl_res;
    logic [15:0] hlf_res;
    logic [63:0] packed_res;

    always_comb begin
        round_up = s1_guard & (s1_sticky | s1_mant[0]);
        // Adding across the exponent/mantissa boundary lets a mantissa carry bump the
        // exponent (subnormal -> min normal, max normal -> infinity) with no extra logic.
        sgl_mag  = {s1_exp, s1_mant} + 31'(round_up);
        hlf_mag  = {s1_exp[4:0], s1_mant[9:0]} + 15'(round_up);

        case (s1_cls)
            CLS_ZERO: begin
                sgl_res = {s1_sign, 31'd0};
                hlf_res = {s1_sign, 15'd0};
            end
            CLS_INF: begin
                sgl_res = {s1_sign, 31'h7F800000};
                hlf_res = {s1_sign, 15'h7C00};
            end
            CLS_NAN: begin
                sgl_res = {s1_sign, 31'h7FC00000};
                hlf_res = {s1_sign, 15'h7E00};
            end
            default: begin
                sgl_res = {s1_sign, sgl_mag};
                hlf_res = {s1_sign, hlf_mag};
            end
        endcase

        if (s1_mode[1]) begin
            packed_res = s1_raw;
        end else if (s1_mode[0]) begin
            packed_res = {32'd0, sgl_res};
        end else begin
            packed_res = {48'd0, hlf_res};
        end
    end

    generate
        if (PIPE_OUT_REG) begin : g_out_reg
            logic        s2_valid;
            logic [63:0] s2_data;

            assign s2_ready = !s2_valid || output_ready;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s2_valid <= 1'b0;
                    s2_data  <= 64'd0;
                end else if (s2_ready) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= packed_res;
                    end
                end
            end

            assign output_valid = s2_valid;
            assign output_data  = s2_data;
        end else begin : g_out_comb
            assign s2_ready     = output_ready;
            assign output_valid = s1_valid;
            assign output_data  = packed_res;
        end
    endgenerate

endmodule

// File: tb/tb_radix_down_converter.sv
// Directed and streamed checks of radix_down_converter (PIPE_OUT_REG=1).
// Ports: drives every DUT port; clk from a #5 toggle.
module tb_radix_down_converter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  Ctrl_sig;
    logic        input_valid;
    logic        input_ready;
    logic [63:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [63:0] output_data;

    always #5 clk = ~clk;

    radix_down_converter #(.PIPE_OUT_REG(1'b1)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .Ctrl_sig    (Ctrl_sig),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_data  (input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_data (output_data)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] din;
        logic [63:0] want;
    } vec_t;

    vec_t dir_vecs [19] = '{
        '{2'd1, 64'h3FF0000000000000, 64'h000000003F800000},
        '{2'd1, 64'h400921FB54442D18, 64'h0000000040490FDB},
        '{2'd1, 64'h3FF0000010000000, 64'h000000003F800000},
        '{2'd1, 64'h3FF0000030000000, 64'h000000003F800002},
        '{2'd0, 64'h3FF0000000000000, 64'h0000000000003C00},
        '{2'd0, 64'h400921FB54442D18, 64'h0000000000004248},
        '{2'd0, 64'h40EFFC0000000000, 64'h0000000000007BFF},
        '{2'd0, 64'h40EFFE0000000000, 64'h0000000000007C00},
        '{2'd0, 64'h3E70000000000000, 64'h0000000000000001},
        '{2'd0, 64'hC202A05F20000000, 64'h000000000000FC00},
        '{2'd1, 64'h7FF0000000000001, 64'h000000007FC00000},
        '{2'd0, 64'h7FF0000000000001, 64'h0000000000007E00},
        '{2'd1, 64'hFFF0000000000000, 64'h00000000FF800000},
        '{2'd0, 64'hFFF0000000000000, 64'h000000000000FC00},
        '{2'd1, 64'h8000000000000001, 64'h0000000080000000},
        '{2'd0, 64'h8000000000000001, 64'h0000000000008000},
        '{2'd0, 64'h3F0FFE0000000000, 64'h0000000000000400},
        '{2'd1, 64'h47EFFFFFF0000000, 64'h000000007F800000},
        '{2'd3, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer quotient/remainder rounding on the exact significand.
    function automatic logic [63:0] ref_conv(input logic [1:0] mode, input logic [63:0] x);
        int          e, m, bias, emin, width, big_e, q, k, ef, emax_f;
        logic [63:0] sig, n, rem, half, res;
        if (mode[1]) return x;
        m      = mode[0] ? 23 : 10;
        bias   = mode[0] ? 127 : 15;
        width  = mode[0] ? 32 : 16;
        emin   = 1 - bias;
        emax_f = 2 * bias + 1;
        e      = int'(x[62:52]);
        if (e == 2047) begin
            res = 64'(emax_f) << m;
            if (x[51:0] != 52'd0) res = res | (64'd1 << (m - 1));
        end else if (e == 0) begin
            res = 64'd0;
        end else begin
            big_e = e - 1023;
            sig   = {11'd0, 1'b1, x[51:0]};
            q     = ((big_e > emin) ? big_e : emin) - m;
            k     = q - (big_e - 52);
            if (k > 53) begin
                n = 64'd0;
            end else begin
                n    = sig >> k;
                rem  = sig - (n << k);
                half = 64'd1 << (k - 1);
                if (rem > half || (rem == half && n[0])) n = n + 64'd1;
            end
            if (n < (64'd1 << m)) begin
                res = n;
            end else begin
                ef = q + m + bias;
                if (n >= (64'd1 << (m + 1))) begin
                    ef = ef + 1;
                    n  = n >> 1;
                end
                if (ef >= emax_f) res = 64'(emax_f) << m;
                else              res = (64'(ef) << m) | (n - (64'd1 << m));
            end
        end
        res = res | (64'(x[63]) << (width - 1));
        return res;
    endfunction

    function automatic logic [63:0] rand_f64();
        logic [63:0] x;
        logic [10:0] e;
        x = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       e = x[62:52];
            1, 2, 3: e = 11'($urandom_range(995, 1045));
            4, 5:    e = 11'($urandom_range(870, 1155));
            6: begin
                e = 11'($urandom_range(995, 1045));
                x[39:0] = '0;
            end
            default: e = ($urandom_range(0, 1) != 0) ? 11'h7FF : 11'h000;
        endcase
        x[62:52] = e;
        return x;
    endfunction

    task automatic one_beat(input string tag, input logic [1:0] mode,
                            input logic [63:0] din, input logic [63:0] want);
        int lat;
        int wait_cnt;
        Ctrl_sig     = mode;
        input_data   = din;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        #1;
        wait_cnt = 0;
        while (!input_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check({tag, "_acc"}, 64'(input_ready), 64'd1);
        tick();
        // Change the inputs right after acceptance: the captured beat must not follow.
        input_valid = 1'b0;
        Ctrl_sig    = ~mode;
        input_data  = ~din;
        lat = 1;
        while (!output_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check(tag, output_data, want);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic        stale;
        int          accepted;
        int          cycles;
        int          occ;
        logic [1:0]  cur_mode;
        logic [63:0] cur_data;
        logic [63:0] got;

        // ---- reset from power-up ----
        rstn         = 1'b0;
        Ctrl_sig     = 2'd0;
        input_valid  = 1'b0;
        input_data   = 64'd0;
        output_ready = 1'b0;
        repeat (3) tick();
        check("rst_vld", 64'(output_valid), 64'd0);
        check("rst_dat", output_data, 64'd0);
        rstn = 1'b1;
        tick();

        // ---- fill both stages, then reset with beats in flight ----
        Ctrl_sig    = 2'd1;
        input_data  = 64'h3FF0000000000000;
        input_valid = 1'b1;
        tick();
        input_data = 64'h4000000000000000;
        tick();
        input_valid = 1'b0;
        check("full_rdy", 64'(input_ready), 64'd0);
        rstn = 1'b0;
        tick();
        check("inflight_rst_vld", 64'(output_valid), 64'd0);
        check("inflight_rst_dat", output_data, 64'd0);
        tick();
        rstn         = 1'b1;
        output_ready = 1'b1;
        stale        = 1'b0;
        repeat (6) begin
            tick();
            if (output_valid) stale = 1'b1;
        end
        check("no_stale", 64'(stale), 64'd0);

        // ---- directed conversions ----
        for (int i = 0; i < 19; i++) begin
            one_beat($sformatf("dir%0d", i), dir_vecs[i].mode, dir_vecs[i].din, dir_vecs[i].want);
        end

        // ---- passthrough with output held off ----
        Ctrl_sig     = 2'd2;
        input_data   = 64'hDEADBEEFCAFEF00D;
        input_valid  = 1'b1;
        output_ready = 1'b0;
        #1;
        check("pass_acc", 64'(input_ready), 64'd1);
        tick();
        input_valid = 1'b0;
        Ctrl_sig    = 2'd0;
        input_data  = 64'd0;
        lat = 1;
        while (!output_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("pass_lat", 64'(lat), 64'd2);
        repeat (3) begin
            check("pass_hold_vld", 64'(output_valid), 64'd1);
            check("pass_hold_dat", output_data, 64'hDEADBEEFCAFEF00D);
            tick();
        end
        output_ready = 1'b1;
        tick();
        check("pass_drained", 64'(output_valid), 64'd0);

        // ---- random stream with per-beat mode switching ----
        accepted = 0;
        cycles   = 0;
        cur_mode = 2'($urandom_range(0, 2));
        cur_data = rand_f64();
        while ((accepted < 64 || sb_q.size() != 0) && cycles < 4000) begin
            input_valid  = (accepted < 64);
            Ctrl_sig     = cur_mode;
            input_data   = cur_data;
            output_ready = (accepted >= 40 && accepted < 56) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            occ = sb_q.size();
            check("in_rdy", 64'(input_ready), 64'(!(occ == 2 && !output_ready)));
            if (output_valid && output_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'(output_valid), 64'd0);
                end else begin
                    got = sb_q.pop_front();
                    check("stream", output_data, got);
                end
            end
            if (input_valid && input_ready) begin
                sb_q.push_back(ref_conv(cur_mode, cur_data));
                accepted++;
                cur_mode = 2'($urandom_range(0, 2));
                cur_data = rand_f64();
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        input_valid = 1'b0;
        check("stream_accepted", 64'(accepted), 64'd64);
        check("stream_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
